nios2_pio_gen: RTL and testbench
================================

NIOS2_PIO_GEN -- requirements
Module: nios2_pio_gen

Interface
REQ-001 Parameter WIDTH, default 8: number of PIO bits, legal range 1..32.
REQ-002 Parameter RESET_VALUE, default 0: reset value of the output data register, WIDTH bits.
REQ-003 Parameter EDGE_TYPE, default 0: edge captured; 0 rising, 1 falling, 2 any.
REQ-004 Parameter IRQ_TYPE, default 0: 0 level IRQ, 1 edge IRQ.
REQ-005 Port clk, input, 1: sole clock; all state is posedge clk.
REQ-006 Port reset_n, input, 1: reset, asynchronous and active-low.
REQ-007 Port address, input, 3: Avalon-MM register word address.
REQ-008 Port chipselect, input, 1: slave select.
REQ-009 Port write_n, input, 1: active-low write strobe.
REQ-010 Port writedata, input, 32: write data.
REQ-011 Port readdata, output, 32: read data, zero wait states, combinational from address and registers.
REQ-012 Port in_port, input, WIDTH: asynchronous external inputs.
REQ-013 Port out_port, output, WIDTH: output data register.
REQ-014 Port oe, output, WIDTH: per-bit output enable, equal to the direction register.
REQ-015 Port irq, output, 1: interrupt request, active-high.

Function
REQ-016 Write occurs when chipselect=1, write_n=0; takes effect at that clk edge; writedata bits at or above WIDTH are ignored.
REQ-017 Address map: 0 data, 1 direction, 2 irqmask, 3 edgecapture, 4 outset, 5 outclear, 6-7 reserved.
REQ-018 Write to addr 0 loads data_out; write to addr 4 sets data_out |= writedata; write to addr 5 sets data_out &= ~writedata.
REQ-019 Write to addr 1 loads direction (1 = output); write to addr 2 loads irqmask.
REQ-020 Write to addr 3 clears each edgecapture bit whose writedata bit is 1; 0 bits are unaffected.
REQ-021 Read addr 0 returns bit i = direction[i] ? data_out[i] : data_in[i]; addr 1/2/3 return the register; addr 4-7 return 0; bits at or above WIDTH always read 0.
REQ-022 in_port passes through a 2-flop synchroniser; in_port sampled at edge k is data_in after edge k+1.
REQ-023 An edge register holds data_in delayed one cycle; a qualifying edge per EDGE_TYPE between data_in and the delayed value sets edgecapture[i] at edge k+2.
REQ-024 Edge detection and capture operate regardless of direction and irqmask.
REQ-025 A simultaneous set from a new edge and a clear write on the same bit leaves the bit set; edges are never lost.
REQ-026 IRQ_TYPE=0: irq = OR(data_in & irqmask); IRQ_TYPE=1: irq = OR(edgecapture & irqmask); irq is combinational from registers.
REQ-027 Reserved-address writes and reads with chipselect=0 have no side effect.

Reset
REQ-028 On reset_n=0, asynchronously: data_out=RESET_VALUE, direction=0, irqmask=0, edgecapture=0, synchroniser and delay flops=0, irq=0.
REQ-029 An input held high through reset release produces one rising edge, captured at edge 3 after release when EDGE_TYPE is 0 or 2.
REQ-030 Reset asserted mid-write discards the write.

Structure
REQ-031 Shared package nios2_pio_pkg holds register address constants and the EDGE_TYPE/IRQ_TYPE encodings.
REQ-032 One sub-module nios2_pio_sync, parametrised by WIDTH and EDGE_TYPE, provides the 2-flop synchroniser, delay flop and edge-pulse vector.

Verification
REQ-033 Reset check: WIDTH=8, RESET_VALUE=0xA5, reset -> out_port=0xA5, oe=0, irq=0, all reads 0 except addr 0 = data_in.
REQ-034 Set/clear check: write addr0 0x0F, addr4 0xF0, addr5 0x03 -> out_port 0x0F, 0xFF, 0xFC on successive cycles.
REQ-035 Direction check: direction=0x0F, in_port=0x30, data_out=0x05 -> read addr0 = 0x35 after 2 cycles.
REQ-036 Edge/IRQ check: IRQ_TYPE=1, EDGE_TYPE=0, irqmask=0x01, pulse in_port[0] -> edgecapture=0x01 and irq=1 at edge k+2; write addr3 0x01 -> irq=0.
REQ-037 Collision check: clear write to addr3 bit 0 on the same cycle a new rising edge is captured -> edgecapture[0] stays 1.
REQ-038 Level IRQ check: IRQ_TYPE=0, irqmask=0x80, in_port[7]=1 -> irq=1 after 2 cycles; irqmask=0 -> irq=0 next cycle.

Source files
------------

// File: rtl/nios2_pio_pkg.sv
// Shared definitions for the Nios II style PIO: register word addresses
// and the encodings of the EDGE_TYPE / IRQ_TYPE parameters.
package nios2_pio_pkg;

    typedef enum logic [2:0] {
        ADDR_DATA      = 3'd0,
        ADDR_DIRECTION = 3'd1,
        ADDR_IRQMASK   = 3'd2,
        ADDR_EDGECAP   = 3'd3,
        ADDR_OUTSET    = 3'd4,
        ADDR_OUTCLEAR  = 3'd5
    } pio_addr_e;

    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;

    localparam int IRQ_LEVEL = 0;
    localparam int IRQ_EDGE  = 1;

endpackage

// File: rtl/nios2_pio_sync.sv
// Input conditioning for the PIO pins: two-flop synchroniser, one-cycle
// delay flop and the per-bit edge pulse selected by EDGE_TYPE.
module nios2_pio_sync
    import nios2_pio_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int EDGE_TYPE = EDGE_RISING
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_data_in,
    output logic [WIDTH-1:0] o_edge_pulse
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;
    logic [WIDTH-1:0] r_dly;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour; blocking here would
    // collapse the three stages into one.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_meta <= '0;
            r_sync <= '0;
            r_dly  <= '0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_dly  <= r_sync;
        end
    end

    // NOTE: the default assignment first keeps this combinational block
    // from inferring a latch for any EDGE_TYPE value.
    always_comb begin
        o_edge_pulse = '0;
        case (EDGE_TYPE)
            EDGE_RISING:  o_edge_pulse = r_sync & ~r_dly;
            EDGE_FALLING: o_edge_pulse = ~r_sync & r_dly;
            default:      o_edge_pulse = r_sync ^ r_dly;
        endcase
    end

    assign o_data_in = r_sync;

endmodule

// File: rtl/nios2_pio_gen.sv
// Avalon-MM parallel I/O port: data/direction/irqmask/edgecapture registers,
// atomic output set/clear, synchronised inputs with edge capture and IRQ.
module nios2_pio_gen
    import nios2_pio_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               EDGE_TYPE   = EDGE_RISING,
    parameter int               IRQ_TYPE    = IRQ_LEVEL
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic [WIDTH-1:0] oe,
    output logic             irq
);

    logic [WIDTH-1:0] r_data_out;
    logic [WIDTH-1:0] r_direction;
    logic [WIDTH-1:0] r_irqmask;
    logic [WIDTH-1:0] r_edgecap;

    logic [WIDTH-1:0] w_data_in;
    logic [WIDTH-1:0] w_edge_pulse;
    logic [WIDTH-1:0] w_wd;
    logic [WIDTH-1:0] w_ec_clear;
    logic [WIDTH-1:0] w_pin_read;
    logic             w_wr;
    logic             w_unused_wd;

    assign w_wr        = chipselect & ~write_n;
    assign w_wd        = writedata[WIDTH-1:0];
    assign w_unused_wd = ^writedata;
    assign w_ec_clear  = (w_wr && address == ADDR_EDGECAP) ? w_wd : '0;

    nios2_pio_sync #(
        .WIDTH     (WIDTH),
        .EDGE_TYPE (EDGE_TYPE)
    ) u_sync (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_async      (in_port),
        .o_data_in    (w_data_in),
        .o_edge_pulse (w_edge_pulse)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data_out  <= RESET_VALUE;
            r_direction <= '0;
            r_irqmask   <= '0;
            r_edgecap   <= '0;
        end else begin
            // Set is applied after clear so an edge arriving with a clear write survives.
            r_edgecap <= (r_edgecap & ~w_ec_clear) | w_edge_pulse;
            if (w_wr) begin
                case (address)
                    ADDR_DATA:      r_data_out  <= w_wd;
                    ADDR_DIRECTION: r_direction <= w_wd;
                    ADDR_IRQMASK:   r_irqmask   <= w_wd;
                    ADDR_OUTSET:    r_data_out  <= r_data_out | w_wd;
                    ADDR_OUTCLEAR:  r_data_out  <= r_data_out & ~w_wd;
                    default:        ;
                endcase
            end
        end
    end

    assign w_pin_read = (r_direction & r_data_out) | (~r_direction & w_data_in);

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:      readdata[WIDTH-1:0] = w_pin_read;
            ADDR_DIRECTION: readdata[WIDTH-1:0] = r_direction;
            ADDR_IRQMASK:   readdata[WIDTH-1:0] = r_irqmask;
            ADDR_EDGECAP:   readdata[WIDTH-1:0] = r_edgecap;
            default:        readdata = '0;
        endcase
    end

    generate
        if (IRQ_TYPE == IRQ_LEVEL) begin : g_irq_level
            assign irq = |(w_data_in & r_irqmask);
        end else begin : g_irq_edge
            assign irq = |(r_edgecap & r_irqmask);
        end
    endgenerate

    assign out_port = r_data_out;
    assign oe       = r_direction;

endmodule

// File: tb/tb_nios2_pio_gen.sv
// Self-checking bench for nios2_pio_gen: directed register/edge/IRQ steps
// followed by random bus and pin traffic against a behavioural model.
module tb_nios2_pio_gen;

    localparam logic [7:0] RV = 8'hA5;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [7:0]  in_port;

    logic [31:0] rd_e, rd_l;
    logic [7:0]  out_e, out_l, oe_e, oe_l;
    logic        irq_e, irq_l;

    int errors = 0;
    int checks = 0;

    // Reference state: registers plus the last three pin samples (index 0 newest).
    logic [7:0] m_out, m_dir, m_mask, m_ec;
    logic [7:0] m_hist [3];

    always #10 clk = ~clk;

    nios2_pio_gen #(.WIDTH(8), .RESET_VALUE(RV), .EDGE_TYPE(0), .IRQ_TYPE(1)) dut_e (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd_e),
        .in_port(in_port), .out_port(out_e), .oe(oe_e), .irq(irq_e)
    );

    nios2_pio_gen #(.WIDTH(8), .RESET_VALUE(RV), .EDGE_TYPE(0), .IRQ_TYPE(0)) dut_l (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd_l),
        .in_port(in_port), .out_port(out_l), .oe(oe_l), .irq(irq_l)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_out  = RV;
        m_dir  = 8'h00;
        m_mask = 8'h00;
        m_ec   = 8'h00;
        for (int i = 0; i < 3; i++) m_hist[i] = 8'h00;
    endtask

    // Applies one clock edge worth of behaviour using the pre-edge inputs.
    task automatic model_edge();
        logic [7:0] rise;
        logic [7:0] wd;
        logic       wr;
        if (!reset_n) return;
        rise = m_hist[1] & ~m_hist[2];
        wd   = writedata[7:0];
        wr   = chipselect && !write_n;
        if (wr && address == 3'd3) m_ec = m_ec & ~wd;
        m_ec = m_ec | rise;
        if (wr) begin
            case (address)
                3'd0: m_out  = wd;
                3'd1: m_dir  = wd;
                3'd2: m_mask = wd;
                3'd4: m_out  = m_out | wd;
                3'd5: m_out  = m_out & ~wd;
                default: ;
            endcase
        end
        m_hist[2] = m_hist[1];
        m_hist[1] = m_hist[0];
        m_hist[0] = in_port;
    endtask

    function automatic logic [31:0] exp_read(input logic [2:0] a);
        case (a)
            3'd0:    return 32'((m_dir & m_out) | (~m_dir & m_hist[1]));
            3'd1:    return 32'(m_dir);
            3'd2:    return 32'(m_mask);
            3'd3:    return 32'(m_ec);
            default: return 32'h0;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        chipselect = 1'b0;
        write_n    = 1'b1;
        tick();
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic read_dut(input logic [2:0] a, output logic [31:0] v);
        chipselect = 1'b1;
        write_n    = 1'b1;
        address    = a;
        #1;
        v = rd_e;
    endtask

    task automatic check_model(input string tag);
        check({tag, "_out"},   32'(out_e),  32'(m_out));
        check({tag, "_outl"},  32'(out_l),  32'(m_out));
        check({tag, "_oe"},    32'(oe_e),   32'(m_dir));
        check({tag, "_irqe"},  32'(irq_e),  32'(|(m_ec & m_mask)));
        check({tag, "_irql"},  32'(irq_l),  32'(|(m_hist[1] & m_mask)));
        check({tag, "_rde"},   rd_e,        exp_read(address));
        check({tag, "_rdl"},   rd_l,        exp_read(address));
    endtask

    initial begin
        logic [31:0] v;

        reset_n    = 1'b0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 3'd0;
        writedata  = 32'h0;
        in_port    = 8'h00;
        model_reset();
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        check("rst_out", 32'(out_e), 32'h0000_00A5);
        check("rst_oe",  32'(oe_e),  32'h0);
        check("rst_irqe", 32'(irq_e), 32'h0);
        check("rst_irql", 32'(irq_l), 32'h0);
        for (int a = 0; a < 8; a++) begin
            read_dut(3'(a), v);
            check($sformatf("rst_rd%0d", a), v, 32'h0);
        end
        reset_n = 1'b1;

        // Load / set / clear, with junk above WIDTH on the load
        bus_write(3'd0, 32'h1234_560F);
        check("load_out", 32'(out_e), 32'h0F);
        bus_write(3'd4, 32'h0000_00F0);
        check("set_out", 32'(out_e), 32'hFF);
        bus_write(3'd5, 32'h0000_0003);
        check("clr_out", 32'(out_e), 32'hFC);

        // Mixed direction readback
        bus_write(3'd1, 32'h0F);
        in_port = 8'h30;
        bus_write(3'd0, 32'h05);
        idle();
        read_dut(3'd0, v);
        check("dir_rd0", v, 32'h35);
        check_model("dir");
        for (int a = 0; a < 8; a++) begin
            read_dut(3'(a), v);
            check($sformatf("dir_rd%0d", a), v, exp_read(3'(a)));
        end

        // Edge capture and edge IRQ
        in_port = 8'h00;
        repeat (3) idle();
        bus_write(3'd3, 32'hFF);
        bus_write(3'd2, 32'h01);
        read_dut(3'd3, v);
        check("edge_pre_ec", v, 32'h0);
        chipselect = 1'b0;
        in_port = 8'h01;
        idle();
        in_port = 8'h00;
        read_dut(3'd3, v);
        check("edge_k_ec", v, 32'h0);
        idle();
        read_dut(3'd3, v);
        check("edge_k1_ec", v, 32'h0);
        check("edge_k1_irq", 32'(irq_e), 32'h0);
        idle();
        read_dut(3'd3, v);
        check("edge_k2_ec", v, 32'h01);
        check("edge_k2_irq", 32'(irq_e), 32'h1);
        bus_write(3'd3, 32'h01);
        check("edge_clr_irq", 32'(irq_e), 32'h0);
        check_model("edge");

        // Clear write colliding with a new captured edge
        repeat (2) idle();
        in_port = 8'h01;
        idle();
        idle();
        bus_write(3'd3, 32'h01);
        read_dut(3'd3, v);
        check("coll_ec", v, 32'h01);
        check("coll_irq", 32'(irq_e), 32'h1);
        bus_write(3'd3, 32'h01);
        read_dut(3'd3, v);
        check("coll_clr_ec", v, 32'h0);

        // Level IRQ
        bus_write(3'd2, 32'h80);
        in_port = 8'h80;
        idle();
        check("lvl_k_irq", 32'(irq_l), 32'h0);
        idle();
        check("lvl_k1_irq", 32'(irq_l), 32'h1);
        bus_write(3'd2, 32'h00);
        check("lvl_off_irq", 32'(irq_l), 32'h0);
        check_model("lvl");

        // Reset during a pending write discards it; pins held high through release
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = 3'd0;
        writedata  = 32'h00;
        in_port    = 8'hFF;
        @(posedge clk);
        #5;
        reset_n = 1'b0;
        model_reset();
        #1;
        check("mid_rst_out", 32'(out_e), 32'hA5);
        @(posedge clk);
        #1;
        check("mid_rst_hold", 32'(out_e), 32'hA5);
        chipselect = 1'b0;
        write_n    = 1'b1;
        #2;
        reset_n = 1'b1;
        idle();
        read_dut(3'd3, v);
        check("rel_e1_ec", v, 32'h0);
        idle();
        read_dut(3'd3, v);
        check("rel_e2_ec", v, 32'h0);
        idle();
        read_dut(3'd3, v);
        check("rel_e3_ec", v, 32'hFF);
        check_model("rel");

        // Random bus and pin traffic
        for (int n = 0; n < 400; n++) begin
            chipselect = 1'($urandom_range(0, 1));
            write_n    = 1'($urandom_range(0, 1));
            address    = 3'($urandom_range(0, 7));
            writedata  = $urandom;
            if ($urandom_range(0, 3) == 0) in_port = 8'($urandom);
            tick();
            check_model($sformatf("rnd%0d", n));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
